// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter slice.
// Only the default counter width lives here.
package counter_pkg;

  localparam int COUNTER_WIDTH = 4;

endpackage

// File: rtl/counter.sv
// Free-running up/down counter with synchronous active-high reset.
// Steps by one every clock in the direction given by `up`, wrapping modulo 2^WIDTH.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Carry/borrow out of the top bit is dropped, which gives the wrap for free.
  always_comb begin
    count_d = count_q;
    if (up) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign dout = count_q;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: stimulus pushes expected counts from a modular
// arithmetic model, an independent monitor pops and compares after each edge.
module tb_counter;

  localparam int WIDTH = 4;
  localparam int MODULUS = 16;

  logic             clk;
  logic             rst;
  logic             up;
  logic [WIDTH-1:0] dout;

  int checks = 0;
  int errors = 0;
  int cycleNum = 0;
  int modelCount = 0;
  logic [WIDTH-1:0] expQ[$];
  bit stimDone = 0;

  counter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .up  (up),
    .dout(dout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Drive inputs on the falling edge, then predict what the next rising edge yields.
  task automatic applyStimulus(input logic r, input logic u);
    @(negedge clk);
    rst = r;
    up  = u;
    if (r) begin
      modelCount = 0;
    end else if (u) begin
      modelCount = (modelCount + 1) % MODULUS;
    end else begin
      modelCount = (modelCount + MODULUS - 1) % MODULUS;
    end
    expQ.push_back(WIDTH'(modelCount));
  endtask

  task automatic checkOutput(input logic [WIDTH-1:0] expVal);
    checks++;
    if ($isunknown(dout) || dout !== expVal) begin
      errors++;
      $display("[TB] FAIL dout_cycle%0d: got %h expected %h", cycleNum, dout, expVal);
    end
  endtask

  // Monitor: the counter presents a new value after every rising edge.
  initial begin
    logic [WIDTH-1:0] expVal;
    forever begin
      @(posedge clk);
      #1;
      cycleNum++;
      if (expQ.size() > 0) begin
        expVal = expQ.pop_front();
        checkOutput(expVal);
      end
    end
  end

  initial begin
    rst = 1'b1;
    up  = 1'b0;

    // Power-up reset held for three cycles.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

    // Count up 20 cycles: 1..15, 0, 1..4.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1);

    // Reset then count down through the 0 -> 15 wrap.
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);

    // Up to 7, down three, back up two.
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1);

    // Up to 9, reset for two cycles, release in down mode.
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);

    // Reset while toggling direction in the same cycles.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);

    // Random run.
    for (int i = 0; i < 360; i++) begin
      applyStimulus(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 1)));
    end
    stimDone = 1;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
